// File: rtl/mem_copy_pkg.sv
// Shared definitions for the word-by-word memory copy engine.
`timescale 1ns/1ps
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int ADDR_STEP_DEF = 4;

endpackage

// File: rtl/mem_copy_engine.sv
// Single-port memory copy engine: alternates one READ and one WRITE cycle per word,
// then pulses Done in FINISH. All memory-side outputs are registered.
`timescale 1ns/1ps
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [31:0]      SrcAddr,
  input  logic [31:0]      DstAddr,
  input  logic [CNT_W-1:0] WordCount,
  output logic [31:0]      Address,
  output logic [31:0]      WriteData,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [31:0]      ReadData,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] WordsCopied
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  state_t           r_state;
  logic [31:0]      r_src, r_dst, r_addr, r_wdata;
  logic [CNT_W-1:0] r_count, r_copied;
  logic             r_rd, r_wr, r_busy, r_done;

  logic [31:0]      w_src_nxt, w_dst_nxt;
  logic [CNT_W-1:0] w_copied_nxt;
  logic             w_more;

  assign w_src_nxt    = r_src + STEP;
  assign w_dst_nxt    = r_dst + STEP;
  assign w_copied_nxt = r_copied + 1'b1;
  assign w_more       = (w_copied_nxt < r_count);

  // Outputs are loaded on the edge that enters a state, so they are valid
  // for the whole cycle the state occupies.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_count  <= '0;
      r_copied <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_src    <= SrcAddr;
            r_dst    <= DstAddr;
            r_count  <= WordCount;
            r_copied <= '0;
            if (WordCount != '0) begin
              r_state <= READ;
              r_addr  <= SrcAddr;
              r_rd    <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          r_state <= WRITE;
          r_wdata <= ReadData;
          r_addr  <= r_dst;
          r_rd    <= 1'b0;
          r_wr    <= 1'b1;
        end
        WRITE: begin
          r_src    <= w_src_nxt;
          r_dst    <= w_dst_nxt;
          r_copied <= w_copied_nxt;
          r_wr     <= 1'b0;
          r_wdata  <= '0;
          if (w_more) begin
            r_state <= READ;
            r_addr  <= w_src_nxt;
            r_rd    <= 1'b1;
          end else begin
            r_state <= FINISH;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Address     = r_addr;
  assign WriteData   = r_wdata;
  assign MemRead     = r_rd;
  assign MemWrite    = r_wr;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign WordsCopied = r_copied;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: CNT_W, 8, width of word-count and progress signals.
REQ-002 Parameter: ADDR_STEP, 4, byte increment between consecutive 32-bit words.
REQ-003 Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  request a copy, sampled only in IDLE.
REQ-006 SrcAddr  input  32  byte address of the first source word, sampled with Start.
REQ-007 DstAddr  input  32  byte address of the first destination word, sampled with Start.
REQ-008 WordCount  input  CNT_W  number of words to copy, sampled with Start.
REQ-009 Address  output  32  memory address for the current access.
REQ-010 WriteData  output  32  memory write data.
REQ-011 MemWrite  output  1  memory write enable; memory writes on Clk rising edge.
REQ-012 MemRead  output  1  memory read enable.
REQ-013 ReadData  input  32  memory read data, combinational from Address while MemRead=1.
REQ-014 Busy  output  1  high while a copy is in progress.
REQ-015 Done  output  1  one-cycle pulse at copy completion.
REQ-016 WordsCopied  output  CNT_W  words written so far in the current or last copy.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WRITE and FINISH.
REQ-018 IDLE with Start=1 SHALL latch SrcAddr, DstAddr and WordCount, clear WordsCopied, then go to READ (WordCount>0) or FINISH (WordCount=0).
REQ-019 READ SHALL drive Address=current source, MemRead=1, MemWrite=0, and capture ReadData into an internal data register at the clock edge; next state is WRITE.
REQ-020 WRITE SHALL drive Address=current destination, WriteData=data register, MemWrite=1, MemRead=0; at the edge it adds ADDR_STEP to source and destination (mod 2^32), increments WordsCopied, and goes to READ if words remain, else FINISH.
REQ-021 FINISH SHALL assert Done=1 for exactly one cycle, Busy=0, then go to IDLE.
REQ-022 Busy SHALL be 1 exactly in READ and WRITE.
REQ-023 The latency from a Start-sampling edge to Done is 2*WordCount+1 cycles; Done appears in the cycle after the edge ending the last WRITE.
REQ-024 Start SHALL be ignored outside IDLE; an in-progress copy is never restarted or altered.
REQ-025 Outside READ and WRITE, MemRead and MemWrite SHALL both be 0, Address SHALL be 0 and WriteData SHALL be 0.
REQ-026 MemRead and MemWrite SHALL never be high in the same cycle.
REQ-027 Copies are forward (ascending address); overlapping regions with DstAddr>SrcAddr propagate already-written data, and this is accepted behaviour.
REQ-028 Address arithmetic SHALL wrap modulo 2^32 without error indication.
REQ-029 WordsCopied SHALL hold its final value in IDLE until the next accepted Start.

Reset
REQ-030 Rst=1 at a clock edge SHALL force IDLE, clear the address, count and data registers and WordsCopied, and force Busy=0 and Done=0, also mid-copy; the memory write pending in that cycle still occurs if MemWrite was high before the edge.
REQ-031 Rst SHALL take priority over Start in the same cycle.

Structure
REQ-032 The shared package mem_copy_pkg SHALL hold the state encoding (2-bit enum IDLE=0, READ=1, WRITE=2, FINISH=3) and the ADDR_STEP default.
REQ-033 The block SHALL be a single module with no sub-modules; a DataMemory instance exists only in the bench.

Verification
REQ-034 Memory at 0x00, 0x04, 0x08 preloaded with 0x12345678, 0xABCDEF98, 0xFFFFFFFF; Start with Src=0x00, Dst=0x40, Count=3 -> 0x40, 0x44, 0x48 read back equal, Done 7 cycles after Start, WordsCopied=3.
REQ-035 Start with Count=0 -> no MemRead/MemWrite, Done one cycle after Start, WordsCopied=0.
REQ-036 Start pulsed again in WRITE during a Count=2 copy -> ignored, exactly 2 writes, one Done pulse.
REQ-037 Rst asserted in the second READ of a Count=3 copy -> next cycle IDLE, Busy=0, no further writes; Dst+4 and Dst+8 unchanged.
REQ-038 Src=0xFFFFFFFC, Dst=0x10, Count=2 -> second read at address 0x00000000, no error.
REQ-039 Every cycle of all scenarios -> assertion that MemRead and MemWrite are never both 1.
